muldiv_seq: RTL



---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div sequencer.
// The master drives requests, flush and resp_ready. The slave (muldiv_seq) returns the handshake and the result.
interface muldiv_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        flush;
    logic        busy;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, flush,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, flush,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RISC-V M-extension sequencer: fixed-latency multiply, radix-2 restoring divide, registered result.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete in one cycle.
module muldiv_seq #(
    parameter int MUL_LAT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} stateType;

    stateType    state, nextState;
    logic [6:0]  counter;
    logic [63:0] respData;
    logic        opWord, opRem, quoNeg, remNeg, divZero;
    logic [63:0] mulA, mulB;
    logic [63:0] divRem, divQuo, divisor;

    logic        reqWord, reqDiv, reqRem, reqUns, reqIllegal;
    logic        signA, signB, divByZero, earlyOut, acceptDone;
    logic [63:0] aExt, bExt, magA, magB, specialResult, acceptResult;
    logic [64:0] remShift;
    logic        divFits;
    logic [63:0] remNext, quoVal, remVal, fixResult;

    function automatic logic [63:0] wordFix(input logic isWord, input logic [63:0] v);
        return isWord ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [63:0] mulLow(input logic isWord, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] full;
        logic [31:0] low;
        full = a * b;
        low  = a[31:0] * b[31:0];
        return isWord ? {{32{low[31]}}, low} : full;
    endfunction

    // Request decode: W ops are narrowed to 32 bits and re-extended, then signed operands become magnitudes.
    always_comb begin
        reqWord    = bus.req_op[3];
        reqDiv     = bus.req_op[2];
        reqRem     = bus.req_op[1];
        reqUns     = bus.req_op[0];
        reqIllegal = !reqDiv && (bus.req_op[1:0] != 2'b00);
        aExt = reqWord ? (reqUns ? {32'h0, bus.req_a[31:0]} : {{32{bus.req_a[31]}}, bus.req_a[31:0]}) : bus.req_a;
        bExt = reqWord ? (reqUns ? {32'h0, bus.req_b[31:0]} : {{32{bus.req_b[31]}}, bus.req_b[31:0]}) : bus.req_b;
        signA     = !reqUns && aExt[63];
        signB     = !reqUns && bExt[63];
        magA      = signA ? -aExt : aExt;
        magB      = signB ? -bExt : bExt;
        divByZero = (bExt == 64'h0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic        divOverflow;
    logic [63:0] minVal;

    always_comb begin
        minVal        = reqWord ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        divOverflow   = !reqUns && (aExt == minVal) && (bExt == 64'hFFFF_FFFF_FFFF_FFFF);
        earlyOut      = reqDiv && (divByZero || divOverflow);
        specialResult = divByZero ? (reqRem ? aExt : 64'hFFFF_FFFF_FFFF_FFFF)
                                  : (reqRem ? 64'h0 : minVal);
        specialResult = wordFix(reqWord, specialResult);
    end
`else
    assign earlyOut      = 1'b0;
    assign specialResult = 64'h0;
`endif

    always_comb begin
        acceptDone   = reqIllegal || earlyOut || (!reqDiv && (MUL_LAT == 1));
        acceptResult = reqIllegal ? 64'h0 : (reqDiv ? specialResult : mulLow(reqWord, aExt, bExt));
    end

    // One restoring step per DIV cycle. The magnitude-based quotient is only wrong for a zero divisor, so FIX overrides that case.
    always_comb begin
        remShift  = {divRem, divQuo[63]};
        divFits   = (remShift >= {1'b0, divisor});
        remNext   = divFits ? (remShift[63:0] - divisor) : remShift[63:0];
        quoVal    = quoNeg ? -divQuo : divQuo;
        remVal    = remNeg ? -divRem : divRem;
        fixResult = wordFix(opWord, opRem ? remVal : (divZero ? 64'hFFFF_FFFF_FFFF_FFFF : quoVal));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (bus.flush) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                          if (acceptDone)  nextState = DONE;
                          else if (reqDiv) nextState = DIV;
                          else             nextState = MUL;
                      end
                MUL:  if (counter == 7'd1) nextState = DONE;
                DIV:  if (counter == 7'd1) nextState = FIX;
                FIX:  nextState = DONE;
                DONE: if (bus.resp_ready) nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // A flush freezes the datapath; the stale contents are never presented because resp_valid follows the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= 7'd0;
            respData <= 64'h0;
            opWord   <= 1'b0;
            opRem    <= 1'b0;
            quoNeg   <= 1'b0;
            remNeg   <= 1'b0;
            divZero  <= 1'b0;
            mulA     <= 64'h0;
            mulB     <= 64'h0;
            divRem   <= 64'h0;
            divQuo   <= 64'h0;
            divisor  <= 64'h0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    opWord  <= reqWord;
                    opRem   <= reqRem;
                    quoNeg  <= signA ^ signB;
                    remNeg  <= signA;
                    divZero <= divByZero;
                    mulA    <= aExt;
                    mulB    <= bExt;
                    divRem  <= 64'h0;
                    divQuo  <= reqWord ? {magA[31:0], 32'h0} : magA;
                    divisor <= magB;
                    counter <= reqDiv ? (reqWord ? 7'd32 : 7'd64) : 7'(MUL_LAT - 1);
                    if (acceptDone) respData <= acceptResult;
                end
                MUL: begin
                    counter <= counter - 7'd1;
                    if (counter == 7'd1) respData <= mulLow(opWord, mulA, mulB);
                end
                DIV: begin
                    counter <= counter - 7'd1;
                    divRem  <= remNext;
                    divQuo  <= {divQuo[62:0], divFits};
                end
                FIX: respData <= fixResult;
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE) && !bus.flush;
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_data  = respData;
    assign bus.busy       = (state != IDLE);

endmodule
